// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : Data-memory responder for the RV32 memory-access stage.
//           Adds programmable wait states, byte-lane stores, and
//           sign/zero-extended loads.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             busy
);

  localparam int         c_idx_w  = $clog2(DEPTH_WORDS);
  localparam int         c_lanes  = WIDTH / 8;
  localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [WIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic [1:0]         r_size;
  logic               r_uns;
  logic               r_resp_valid;
  logic [WIDTH-1:0]   r_rdata;
  logic               r_err;
  logic [WIDTH-1:0]   r_mem [DEPTH_WORDS];

  logic [c_idx_w-1:0] w_idx;
  logic               w_oor;
  logic               w_mis;
  logic               w_err;
  logic               w_commit;
  logic [WIDTH-1:0]   w_word;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [c_lanes-1:0] w_be;
  logic [WIDTH-1:0]   w_wlanes;
  logic [WIDTH-1:0]   w_load;

  assign w_idx    = r_addr[c_idx_w+1:2];
  assign w_oor    = |r_addr[WIDTH-1:c_idx_w+2];
  assign w_mis    = ((r_size == 2'd1) && r_addr[0]) ||
                    ((r_size == 2'd2) && (r_addr[1:0] != 2'b00));
  assign w_err    = w_oor || w_mis || (r_size == 2'd3);
  assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_word   = r_mem[w_idx];
  assign w_byte   = w_word[8*r_addr[1:0] +: 8];
  assign w_half   = r_addr[1] ? w_word[31:16] : w_word[15:0];

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be     = '0;
    w_wlanes = r_wdata;
    w_load   = '0;
    case (r_size)
      2'd0: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_wlanes = {4{r_wdata[7:0]}};
        w_load   = {{24{~r_uns & w_byte[7]}}, w_byte};
      end
      2'd1: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
        w_load   = {{16{~r_uns & w_half[15]}}, w_half};
      end
      2'd2: begin
        w_be     = 4'b1111;
        w_load   = w_word;
      end
      default: begin
        w_be     = '0;
      end
    endcase
  end

  // The array is never reset; a reset clears r_state and so blocks the commit.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      for (int i = 0; i < c_lanes; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= 2'd0;
      r_uns        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_cnt   <= c_lat_m1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_we) ? '0 : w_load;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed scoreboard bench for dmem_responder (LATENCY = 2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int c_lat = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   passed    = 0;
  int   failed    = 0;
  int   total     = 0;
  int   n_pushed  = 0;
  int   mon_resp  = 0;

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(c_lat)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_valid) mon_resp <= mon_resp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    q.push_back(e);
    n_pushed = n_pushed + 1;
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle carrying the response.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input logic uns, input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int k;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    push_exp(exp_rdata, exp_err);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    k = 0;
    while (!resp_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(c_lat + 1));
    check_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int acc;
    int nresp;
    int cnt;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req("sw10",   1'b1, 32'h10,   32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0);
    do_req("lw10",   1'b0, 32'h10,   32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    do_req("sb13",   1'b1, 32'h13,   32'h00000080, 2'd0, 1'b0, 32'h0,        1'b0);
    do_req("lb13",   1'b0, 32'h13,   32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 1'b0);
    do_req("lbu13",  1'b0, 32'h13,   32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0);
    do_req("lw10b",  1'b0, 32'h10,   32'h0,        2'd2, 1'b0, 32'h80ADBEEF, 1'b0);
    do_req("sw20",   1'b1, 32'h20,   32'hAAAAAAAA, 2'd2, 1'b0, 32'h0,        1'b0);
    do_req("sh22",   1'b1, 32'h22,   32'h00001234, 2'd1, 1'b0, 32'h0,        1'b0);
    do_req("lw20",   1'b0, 32'h20,   32'h0,        2'd2, 1'b0, 32'h1234AAAA, 1'b0);
    do_req("lh22",   1'b0, 32'h22,   32'h0,        2'd1, 1'b0, 32'h00001234, 1'b0);
    do_req("lh20",   1'b0, 32'h20,   32'h0,        2'd1, 1'b0, 32'hFFFFAAAA, 1'b0);
    do_req("lhu20",  1'b0, 32'h20,   32'h0,        2'd1, 1'b1, 32'h0000AAAA, 1'b0);
    do_req("lw21",   1'b0, 32'h21,   32'h0,        2'd2, 1'b0, 32'h0,        1'b1);
    do_req("lh23",   1'b0, 32'h23,   32'h0,        2'd1, 1'b0, 32'h0,        1'b1);
    do_req("sw0",    1'b1, 32'h0,    32'h0BADF00D, 2'd2, 1'b0, 32'h0,        1'b0);
    do_req("sw1000", 1'b1, 32'h1000, 32'hFFFFFFFF, 2'd2, 1'b0, 32'h0,        1'b1);
    do_req("lw0",    1'b0, 32'h0,    32'h0,        2'd2, 1'b0, 32'h0BADF00D, 1'b0);
    do_req("size3",  1'b0, 32'h10,   32'h0,        2'd3, 1'b0, 32'h0,        1'b1);

    // Back-to-back loads with req_valid held high.
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
    req_valid = 1'b1;
    last = -1; acc = 0; nresp = 0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        check_resp("b2b");
        nresp++;
      end
      if (req_ready) begin
        if (last >= 0) chk("b2b_spacing", 32'(c - last), 32'(c_lat + 2));
        last = c;
        acc++;
        push_exp(32'h80ADBEEF, 1'b0);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) begin
        check_resp("b2b");
        nresp++;
      end
      @(posedge clk); #1;
    end
    chk("b2b_accepts", 32'(acc), 32'd5);
    chk("b2b_resp_count", 32'(nresp), 32'(acc));

    // Reset during WAIT abandons the store.
    do_req("sw40_zero", 1'b1, 32'h40, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_size = 2'd2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_resp", 32'(cnt), 32'd0);
    do_req("lw40", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);

    @(posedge clk); #1;
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("resp_pulse_count", 32'(mon_resp), 32'(n_pushed));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RV32 core. It is the memory-side end of the memory-access stage's load/store request interface. It accepts one request at a time through a valid/ready handshake and holds it for a programmable number of wait states. It then commits stores with byte-lane masking, or returns sign- or zero-extended load data, and issues a single-cycle response. Misaligned and out-of-range accesses are flagged as errors.

## Interface
- WIDTH, 32, data and address width; only 32 is supported
- DEPTH_WORDS, 1024, memory size in 32-bit words; must be a power of two
- LATENCY, 2, wait-state cycles between acceptance and response; legal range 1..15

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  WIDTH  byte address
- req_wdata  input  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as an error
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  WIDTH  load result; 0 for stores and errors
- resp_err  output  1  misaligned, out-of-range or illegal-size access
- busy  output  1  transaction in flight (state is not IDLE)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid, capture we, addr, wdata, size and unsigned into internal registers.
  - Load the wait counter with LATENCY-1 and go to WAIT.
- WAIT
  - req_ready = 0.
  - The counter decrements each cycle. At 0, go to RESP.
  - On that same transition edge: compute the error, perform the store if there is no error, and register the load result.
- RESP
  - resp_valid = 1 for exactly one cycle. There is no backpressure; the core is stalled waiting for it.
  - The next state is always IDLE.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. The access is out of range if any addr bit above that field is 1.
- Misalignment rules: half with addr[0]=1, or word with addr[1:0]≠0, is an error.
- On error: no array write, resp_rdata = 0, resp_err = 1.
- Stores write only the byte lanes that the access covers:
  - byte: lane addr[1:0] gets wdata[7:0]
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0]
  - word: all four lanes
- Loads select the lane or lanes the same way, then sign-extend (req_unsigned=0) or zero-extend (req_unsigned=1) to 32 bits.
- A load followed by a store to the same word returns the old data. A store followed by a load to the same word returns the new data.
- Memory contents are not reset and are not initialised by the block.

## Timing
- Reset values:
  - state IDLE
  - req_ready 1
  - resp_valid 0
  - resp_rdata 0
  - resp_err 0
  - busy 0
  - wait counter 0
- Reset asserted mid-transaction:
  - The transaction is abandoned and no response is issued.
  - A store is not committed if reset arrives before the WAIT→RESP edge.
- Request acceptance edge = T. WAIT occupies cycles T+1..T+LATENCY. resp_valid is high in the cycle after edge T+LATENCY+1.
- resp_rdata and resp_err are valid only while resp_valid=1. They hold their values until the next response.
- The next request is accepted at edge T+LATENCY+2. Throughput is 1 per LATENCY+2 cycles.
- The requester may change req_* freely while req_ready=0. Only the values present at the acceptance edge matter.
- req_valid asserted during WAIT or RESP is ignored until the state returns to IDLE.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (LATENCY=2):
  - each response's resp_valid rises 3 cycles after acceptance
  - LW returns 0xDEADBEEF with resp_err=0
- SB addr 0x13 data 0x80, then:
  - LB 0x13 returns 0xFFFFFF80
  - LBU 0x13 returns 0x00000080
  - LW 0x10 returns 0x80ADBEEF
- SH addr 0x22 data 0x1234 over an existing 0xAAAAAAAA:
  - LW 0x20 returns 0x1234AAAA
  - LH 0x22 returns 0x00001234
- Error cases, each giving resp_err=1 and resp_rdata=0:
  - LW addr 0x21
  - LH addr 0x23
  - SW addr 0x1000 with DEPTH_WORDS=1024; a later LW 0x0 shows the array unchanged
- Hold req_valid high continuously with back-to-back requests:
  - req_ready pulses once every LATENCY+2 cycles
  - exactly one resp_valid per accepted request
- Assert rst during WAIT of SW 0x40 data 0x55 (memory previously 0):
  - busy=0 immediately
  - no resp_valid
  - a subsequent LW 0x40 returns 0
